// File: rtl/mdio_request_arbiter.sv
// Round-robin arbiter sharing one MDIO transaction generator among N_REQ requesters.
// Issues one generator transaction at a time and returns a tagged response on completion or timeout.
module mdio_request_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int WR_WAIT = 70,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 gen_start,
    output logic [31:0]          gen_tdata,
    input  logic [15:0]          gen_rd_data,
    input  logic                 gen_data_rdy
);

    localparam int CNT_MAX = (TIMEOUT > WR_WAIT) ? TIMEOUT : WR_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               prev_rdy_r;

    logic [N_REQ-1:0]   req_ready_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [15:0]        rsp_data_r;
    logic               rsp_err_r;
    logic               busy_r;
    logic               gen_start_r;
    logic [31:0]        gen_tdata_r;

    logic [N_REQ-1:0]   upper_s;
    logic [N_REQ-1:0]   pick_s;
    logic               grant_found_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [31:0]        grant_cmd_s;
    logic               op_valid_s;
    logic               rd_edge_s;
    logic               rd_tmo_s;
    logic               wr_done_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;
    assign gen_start = gen_start_r;
    assign gen_tdata = gen_tdata_r;

    // Round-robin grant: lowest pending index at or above the pointer, else lowest overall
    always_comb begin
        upper_s       = '0;
        grant_id_s    = '0;
        grant_cmd_s   = 32'h0000_0000;
        for (int j = 0; j < N_REQ; j++) begin
            upper_s[j] = req_valid[j] & (j >= int'(rr_ptr_r));
        end
        pick_s        = (|upper_s) ? upper_s : req_valid;
        grant_found_s = |req_valid;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            grant_id_s = pick_s[j] ? ID_W'(j) : grant_id_s;
        end
        for (int j = 0; j < N_REQ; j++) begin
            grant_cmd_s = (grant_id_s == ID_W'(j)) ? req_data[32*j +: 32] : grant_cmd_s;
        end
        op_valid_s = (grant_cmd_s[29:28] == 2'b10) || (grant_cmd_s[29:28] == 2'b01);
    end

    // Completion conditions; a level left high by an earlier read is not an edge
    always_comb begin
        rd_edge_s = gen_data_rdy & ~prev_rdy_r;
        rd_tmo_s  = (cnt_r == CNT_W'(TIMEOUT - 1));
        wr_done_s = (cnt_r == CNT_W'(WR_WAIT - 1));
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nx_s = op_valid_s ? ST_ISSUE : ST_RESP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = (gen_tdata_r[29:28] == 2'b10) ? ST_WAIT_RD : ST_WAIT_WR;
            end
            ST_WAIT_RD: begin
                if (rd_edge_s || rd_tmo_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT_RD;
                end
            end
            ST_WAIT_WR: begin
                if (wr_done_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT_WR;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered outputs, grant bookkeeping and the shared wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r    <= '0;
            id_r        <= '0;
            cnt_r       <= '0;
            prev_rdy_r  <= 1'b0;
            req_ready_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 16'h0000;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            gen_start_r <= 1'b0;
            gen_tdata_r <= 32'h0000_0000;
        end else begin
            req_ready_r <= '0;
            gen_start_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            prev_rdy_r  <= gen_data_rdy;
            busy_r      <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        req_ready_r <= N_REQ'(1) << grant_id_s;
                        id_r        <= grant_id_s;
                        rr_ptr_r    <= (grant_id_s == ID_W'(N_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
                        if (op_valid_s) begin
                            gen_start_r <= 1'b1;
                            gen_tdata_r <= grant_cmd_s;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_id_r    <= grant_id_s;
                            rsp_data_r  <= 16'h0000;
                            rsp_err_r   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= '0;
                end
                ST_WAIT_RD: begin
                    if (rd_edge_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_data_r  <= gen_rd_data;
                        rsp_err_r   <= 1'b0;
                    end else if (rd_tmo_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_data_r  <= 16'h0000;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_WR: begin
                    if (wr_done_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_data_r  <= 16'h0000;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_request_arbiter.sv
// Self-checking bench for mdio_request_arbiter: schedule-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mdio_request_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int WR_WAIT = 70;
    localparam int TIMEOUT = 255;
    localparam longint FAR = 64'd1 << 40;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [32*N_REQ-1:0]  req_data = '0;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic                 gen_start;
    logic [31:0]          gen_tdata;
    logic [15:0]          gen_rd_data = 16'h0000;
    logic                 gen_data_rdy = 1'b0;

    mdio_request_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .WR_WAIT(WR_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .gen_start(gen_start), .gen_tdata(gen_tdata),
        .gen_rd_data(gen_rd_data), .gen_data_rdy(gen_data_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired before the expected event at %0t", name, $time);
    endtask

    // Generator stand-in: after gen_start, optionally drops data_rdy, then raises it after gen_delay
    int   gen_delay = 60;
    int   gen_drop = 0;
    bit   gen_hold = 1'b0;
    bit   gen_silent = 1'b0;
    logic [15:0] gen_val = 16'h0000;
    int   g_cnt = 0;
    bit   g_active = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            gen_data_rdy = 1'b0;
            g_active = 1'b0;
        end else if (gen_start) begin
            g_cnt = 0;
            g_active = 1'b1;
            if (!gen_hold) gen_data_rdy = 1'b0;
        end else if (g_active) begin
            g_cnt++;
            if (g_cnt == gen_drop) gen_data_rdy = 1'b0;
            if (g_cnt == gen_delay) begin
                if (!gen_silent) begin
                    gen_rd_data = gen_val;
                    gen_data_rdy = 1'b1;
                end
                g_active = 1'b0;
            end
        end
    end

    // Reference model: absolute-time schedule of what each output must be in the next cycle
    logic [N_REQ-1:0] m_ready = '0;
    logic             m_start = 1'b0;
    logic [31:0]      m_tdata = 32'h0;
    logic             m_rsp_valid = 1'b0;
    int               m_rsp_id = 0;
    logic [15:0]      m_rsp_data = 16'h0;
    logic             m_rsp_err = 1'b0;
    logic             m_busy = 1'b0;
    int               m_rr = 0;
    int               m_owner = 0;
    longint           cyc = 0;
    longint           free_at = 0;
    longint           rsp_due = 0;
    longint           s_cyc = 0;
    bit               wr_pend = 1'b0;
    bit               rd_pend = 1'b0;
    logic             rdy_last = 1'b0;

    always @(posedge clk) begin
        longint now;
        int g;
        logic [31:0] cmd;
        now = cyc;
        cyc++;
        m_ready = '0;
        m_start = 1'b0;
        m_rsp_valid = 1'b0;
        if (!reset) begin
            m_tdata = 32'h0; m_rsp_id = 0; m_rsp_data = 16'h0; m_rsp_err = 1'b0;
            m_busy = 1'b0; m_rr = 0; free_at = now + 1; wr_pend = 1'b0; rd_pend = 1'b0;
        end else begin
            if (now >= free_at && req_valid != '0) begin
                g = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && req_valid[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
                cmd = req_data[32*g +: 32];
                m_ready[g] = 1'b1;
                m_rr = (g + 1) % N_REQ;
                m_owner = g;
                if (cmd[29:28] == 2'b10) begin
                    m_start = 1'b1; m_tdata = cmd; rd_pend = 1'b1; s_cyc = now + 1; free_at = FAR;
                end else if (cmd[29:28] == 2'b01) begin
                    m_start = 1'b1; m_tdata = cmd; wr_pend = 1'b1;
                    rsp_due = now + 2 + WR_WAIT; free_at = rsp_due + 1;
                end else begin
                    m_rsp_valid = 1'b1; m_rsp_id = g; m_rsp_data = 16'h0; m_rsp_err = 1'b1;
                    free_at = now + 2;
                end
            end else if (wr_pend && now + 1 == rsp_due) begin
                m_rsp_valid = 1'b1; m_rsp_id = m_owner; m_rsp_data = 16'h0; m_rsp_err = 1'b0;
                wr_pend = 1'b0;
            end else if (rd_pend && now > s_cyc) begin
                if (gen_data_rdy && !rdy_last) begin
                    m_rsp_valid = 1'b1; m_rsp_id = m_owner; m_rsp_data = gen_rd_data; m_rsp_err = 1'b0;
                    rd_pend = 1'b0; free_at = now + 2;
                end else if (now == s_cyc + TIMEOUT) begin
                    m_rsp_valid = 1'b1; m_rsp_id = m_owner; m_rsp_data = 16'h0; m_rsp_err = 1'b1;
                    rd_pend = 1'b0; free_at = now + 2;
                end
            end
            m_busy = (now + 1 < free_at);
        end
        rdy_last = gen_data_rdy;
    end

    // Per-cycle comparison against the model, plus event bookkeeping for directed checks
    int ncyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;

    always @(negedge clk) begin
        ncyc++;
        if (gen_start === 1'b1) begin start_cnt++; start_cyc = ncyc; end
        if (rsp_valid === 1'b1) begin rsp_cnt++; rsp_cyc = ncyc; end
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("gen_start", 32'(gen_start), 32'(m_start));
        chk("gen_tdata", gen_tdata, m_tdata);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
        chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
        chk("busy", 32'(busy), 32'(m_busy));
    end

    task automatic set_req(input int i, input logic [31:0] cmd);
        req_valid[i] = 1'b1;
        req_data[32*i +: 32] = cmd;
    endtask

    task automatic wait_ready(input string name, output int idx, output logic [N_REQ-1:0] seen);
        idx = -1;
        seen = '0;
        for (int c = 0; c < 800 && idx < 0; c++) begin
            @(negedge clk); #1;
            if (req_ready != '0) begin
                seen = req_ready;
                for (int j = 0; j < N_REQ; j++) if (req_ready[j]) idx = j;
            end
        end
        if (idx < 0) fail_bound(name);
    endtask

    task automatic wait_rsp(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) fail_bound(name);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); #1;
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_bound(name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_gen_start"}, 32'(gen_start), 32'h0);
        chk({tag, "_gen_tdata"}, gen_tdata, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [1:0] op;
        int r;
        r = int'($urandom_range(0, 5));
        op = (r < 2) ? 2'b10 : (r < 4) ? 2'b01 : (r == 4) ? 2'b00 : 2'b11;
        return {2'b01, op, 5'($urandom), 5'($urandom), 2'b10, 16'($urandom)};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int sc, s0, r0;
        logic [N_REQ-1:0] seen;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Read on requester 2, data_rdy rises 60 cycles after gen_start
        #1;
        gen_delay = 60; gen_val = 16'hBEEF; gen_hold = 1'b0; gen_silent = 1'b0; gen_drop = 0;
        s0 = start_cnt;
        set_req(2, 32'h6082_0000);
        wait_ready("t1_ready", idx, seen);
        req_valid[2] = 1'b0;
        chk("t1_ready_vec", 32'(seen), 32'h4);
        sc = start_cyc;
        wait_rsp("t1_rsp");
        chk("t1_rsp_id", 32'(rsp_id), 32'd2);
        chk("t1_rsp_data", 32'(rsp_data), 32'hBEEF);
        chk("t1_rsp_err", 32'(rsp_err), 32'd0);
        chk("t1_latency", 32'(rsp_cyc - sc), 32'd61);
        chk("t1_start_count", 32'(start_cnt - s0), 32'd1);
        wait_idle("t1_idle");

        // Write on requester 1
        set_req(1, 32'h5002_1234);
        wait_ready("t2_ready", idx, seen);
        req_valid[1] = 1'b0;
        chk("t2_tdata", gen_tdata, 32'h5002_1234);
        sc = start_cyc;
        wait_rsp("t2_rsp");
        chk("t2_latency", 32'(rsp_cyc - sc), 32'd71);
        chk("t2_rsp_id", 32'(rsp_id), 32'd1);
        chk("t2_rsp_err", 32'(rsp_err), 32'd0);
        wait_idle("t2_idle");

        // Invalid opcode on requester 3
        s0 = start_cnt;
        set_req(3, 32'h0000_0000);
        wait_ready("t4_ready", idx, seen);
        req_valid[3] = 1'b0;
        wait_rsp("t4_rsp");
        chk("t4_rsp_id", 32'(rsp_id), 32'd3);
        chk("t4_rsp_err", 32'(rsp_err), 32'd1);
        chk("t4_rsp_data", 32'(rsp_data), 32'd0);
        wait_idle("t4_idle");
        chk("t4_no_start", 32'(start_cnt - s0), 32'd0);

        // All four held high: grants rotate 0,1,2,3,0
        set_req(0, 32'h0000_0000);
        set_req(1, 32'h5002_0000);
        set_req(2, 32'h0000_0000);
        set_req(3, 32'h0000_0000);
        for (int k = 0; k < 5; k++) begin
            wait_ready("t3_ready", idx, seen);
            chk("t3_grant", 32'(idx), 32'(exp_order[k]));
            chk("t3_onehot", 32'($countones(seen)), 32'd1);
        end
        req_valid = '0;
        wait_idle("t3_idle");

        // Silent generator: read times out
        gen_silent = 1'b1;
        set_req(0, 32'h6082_0000);
        wait_ready("t5a_ready", idx, seen);
        req_valid[0] = 1'b0;
        sc = start_cyc;
        wait_rsp("t5a_rsp");
        chk("t5a_latency", 32'(rsp_cyc - sc), 32'(TIMEOUT + 1));
        chk("t5a_rsp_err", 32'(rsp_err), 32'd1);
        chk("t5a_rsp_data", 32'(rsp_data), 32'd0);
        wait_idle("t5a_idle");

        // Leave data_rdy high, then a read that only completes on a fresh rising edge
        gen_silent = 1'b0; gen_delay = 10; gen_val = 16'h1111;
        set_req(1, 32'h6082_0000);
        wait_ready("t5b_ready", idx, seen);
        req_valid[1] = 1'b0;
        wait_rsp("t5b_rsp");
        chk("t5b_rsp_data", 32'(rsp_data), 32'h1111);
        wait_idle("t5b_idle");
        gen_hold = 1'b1; gen_drop = 40; gen_delay = 100; gen_val = 16'h2222;
        set_req(2, 32'h6082_0000);
        wait_ready("t5c_ready", idx, seen);
        req_valid[2] = 1'b0;
        sc = start_cyc;
        wait_rsp("t5c_rsp");
        chk("t5c_latency", 32'(rsp_cyc - sc), 32'd101);
        chk("t5c_rsp_data", 32'(rsp_data), 32'h2222);
        wait_idle("t5c_idle");

        // Reset during WAIT_RD drops the transaction
        gen_hold = 1'b0; gen_drop = 0; gen_silent = 1'b1;
        set_req(2, 32'h6082_0000);
        wait_ready("t6_ready", idx, seen);
        req_valid[2] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        r0 = rsp_cnt;
        reset = 1'b0;
        #1;
        chk_all_zero("t6_async");
        repeat (3) @(negedge clk);
        #1;
        set_req(3, 32'h0000_0000);
        set_req(0, 32'h0000_0000);
        reset = 1'b1;
        chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        wait_ready("t6_first", idx, seen);
        req_valid[0] = 1'b0;
        chk("t6_first_grant", 32'(seen), 32'h1);
        wait_ready("t6_second", idx, seen);
        req_valid[3] = 1'b0;
        chk("t6_second_grant", 32'(idx), 32'd3);
        wait_idle("t6_idle");

        // Randomized traffic checked by the model
        gen_silent = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N_REQ; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, rand_cmd());
            if (req_valid == '0) set_req(int'($urandom_range(0, N_REQ - 1)), rand_cmd());
            gen_delay = int'($urandom_range(1, 300));
            gen_hold = ($urandom_range(0, 3) == 0);
            gen_drop = gen_hold ? int'($urandom_range(1, 32'(gen_delay))) : 0;
            gen_silent = ($urandom_range(0, 9) == 0);
            gen_val = 16'($urandom);
            wait_ready("rnd_ready", idx, seen);
            if (idx >= 0) begin
                if ($urandom_range(0, 1) == 1) req_valid[idx] = 1'b0;
                else req_data[32*idx +: 32] = rand_cmd();
            end
        end
        req_valid = '0;
        wait_idle("rnd_idle");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
